fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data width of each beat and of the FIFO write port.
REQ-002 SHALL have parameter NREQ, default 4, number of write requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port wclk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port wrst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester beat valid.
REQ-007 SHALL have port req_data  input  NREQ*DSIZE  per-requester beat data; requester i in bits [i*DSIZE +: DSIZE].
REQ-008 SHALL have port req_last  input  NREQ  marks the final beat of a requester's packet.
REQ-009 SHALL have port req_ready  output  NREQ  per-requester beat accept.
REQ-010 SHALL have port wfull  input  1  FIFO write-side full flag.
REQ-011 SHALL have port wreq  output  1  FIFO write request.
REQ-012 SHALL have port wdata  output  DSIZE  FIFO write data.
REQ-013 SHALL have port grant_id  output  clog2(NREQ)  index of the current/last granted requester.
REQ-014 SHALL have port busy  output  1  high while in BURST.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and BURST.
REQ-016 In IDLE: wreq=0, req_ready=0; if any req_valid is high, the winner SHALL be chosen round-robin, searching from (grant_id+1) mod NREQ upward, and the next cycle SHALL be BURST with grant_id=winner.
REQ-017 In BURST with granted g: req_ready[g]=~wfull, all other req_ready=0, wreq=req_valid[g]&~wfull, wdata=req_data[g] (combinational path).
REQ-018 A beat SHALL be accepted when req_valid[g]&req_ready[g]; the beat counter increments only on acceptance.
REQ-019 BURST SHALL exit to IDLE on the cycle after an accepted beat with req_last[g]=1 or the MAX_BURST-th accepted beat; the coincident case SHALL exit once.
REQ-020 The exit SHALL leave one IDLE bubble cycle before the next grant; grant_id SHALL hold its value in IDLE.
REQ-021 While wfull=1, no beat SHALL be accepted, and the counter and grant SHALL hold.
REQ-022 If req_valid[g] drops mid-packet, the grant SHALL be held with wreq=0 until the packet completes by REQ-019.
REQ-023 A requester not granted SHALL never see req_ready high, regardless of its valid.
REQ-024 wreq SHALL never be high in the same cycle that wfull is high.

Reset
REQ-025 While wrst=1 at a wclk edge: state=IDLE, beat counter=0, grant_id=NREQ-1 (so requester 0 has first priority), busy=0.
REQ-026 During and after reset, wreq=0 and req_ready=0 until a grant is issued.
REQ-027 Reset asserted mid-burst SHALL abort the packet in the next cycle without any further wreq.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, BURST) and the default DSIZE, NREQ, and MAX_BURST constants.
REQ-029 The round-robin winner search SHALL be a separate combinational sub-module, rr_pick, with inputs (req vector, last grant) and outputs (winner index, any).
REQ-030 The beat counter SHALL be clog2(MAX_BURST+1) bits wide, and grant_id SHALL be a register.

Verification
REQ-031 Reset: hold wrst=1 for 2 cycles with all valids high -> wreq=0, busy=0, req_ready=0, grant_id=3.
REQ-032 Single packet: requester 1 presents 0x11, 0x12, 0x13 (last on 0x13) -> grant_id=1 one cycle after valid; wreq is high 3 consecutive cycles with wdata 0x11, 0x12, 0x13; then busy=0.
REQ-033 Fairness: all 4 requesters valid continuously with last=0 -> grant order 0,1,2,3,0, each grant exactly 4 beats, one idle cycle between grants.
REQ-034 Backpressure: wfull=1 for 3 cycles after beat 2 of requester 0 -> wreq=0 and req_ready=0 during those cycles; the 2 remaining beats follow wfull=0; total 4 beats, no data lost or duplicated.
REQ-035 Reset mid-burst: wrst=1 after beat 1 of requester 2 -> next cycle IDLE with wreq=0; after release, with requesters 0 and 2 valid, requester 0 is granted first.
REQ-036 Coincident exit: req_last=1 on beat 4 with MAX_BURST=4 -> exactly one exit, one bubble, and the next grant goes to the next valid requester.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-side arbiter.
// The FSM state enum and the default DSIZE, NREQ and MAX_BURST values live here.
package fifo_arb_pkg;

  localparam int DEF_DSIZE     = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of the beat counter: it must hold every value from 0 to max_burst.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester handshakes and FIFO write-port signals for the arbiter.
// The master side drives requests and wfull; the slave side is the arbiter.
interface fifo_wr_arbiter_if import fifo_arb_pkg::*; #(
  parameter int DSIZE = DEF_DSIZE,
  parameter int NREQ  = DEF_NREQ
);
  localparam int IW = $clog2(NREQ);

  // A beat moves from requester i when req_valid[i] and req_ready[i] are both
  // high at a wclk edge; data and last must stay stable while valid waits.
  // The FIFO takes wdata at an edge where wreq is high, and wreq is never
  // raised while wfull is high.
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  wreq;
  logic [DSIZE-1:0]      wdata;
  logic [IW-1:0]         grant_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, wreq, wdata, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, wreq, wdata, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_core.sv
// Two-state grant FSM: arbitrate in IDLE, stream the granted requester's
// beats to the FIFO in BURST until its packet ends or the burst cap is hit.
module fifo_wr_arbiter_core import fifo_arb_pkg::*; #(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic              wclk,
  input logic              wrst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = burst_cnt_w(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] pick;
  logic          pick_any;
  logic          accept;
  logic          last_beat;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (bus.req_valid),
    .last   (gnt_q),
    .winner (pick),
    .any    (pick_any)
  );

  // Reset leaves requester 0 as the first one searched.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    bus.req_ready = '0;
    bus.wreq      = 1'b0;
    bus.wdata     = '0;
    accept        = 1'b0;
    last_beat     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          gnt_d   = pick;
          cnt_d   = '0;
        end
      end
      BURST: begin
        bus.wdata = bus.req_data[gnt_q*DSIZE +: DSIZE];
        // Outputs stay quiet while reset is held so an aborted packet
        // leaks no further beat into the FIFO.
        if (!wrst) begin
          bus.req_ready[gnt_q] = ~bus.wfull;
          accept    = bus.req_valid[gnt_q] & ~bus.wfull;
          bus.wreq  = accept;
          last_beat = bus.req_last[gnt_q] || (cnt_q == CW'(MAX_BURST - 1));
          if (accept) begin
            if (last_beat) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign bus.grant_id = gnt_q;
  assign bus.busy     = (state_q == BURST);

endmodule

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin winner search: scans upward from the requester after the last
// grant, wrapping around, and reports the first valid one.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [2*NREQ-1:0] rot;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    // Doubling the vector lets a plain shift perform the modular rotation.
    rot    = {req, req} >> (int'(last) + 1);
    for (int k = 0; k < NREQ; k++) begin
      if (!any && rot[k]) begin
        any    = 1'b1;
        winner = IW'((int'(last) + 1 + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Top level: round-robin arbitration of NREQ packet sources onto one FIFO
// write port, with bursts capped at MAX_BURST beats per grant.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     wreq,
  output logic [DSIZE-1:0]         wdata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

  assign bus.req_valid = req_valid;
  assign bus.req_data  = req_data;
  assign bus.req_last  = req_last;
  assign bus.wfull     = wfull;

  assign req_ready = bus.req_ready;
  assign wreq      = bus.wreq;
  assign wdata     = bus.wdata;
  assign grant_id  = bus.grant_id;
  assign busy      = bus.busy;

  fifo_wr_arbiter_core #(
    .DSIZE     (DSIZE),
    .NREQ      (NREQ),
    .MAX_BURST (MAX_BURST)
  ) u_core (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester beat sources, an expected
// beat queue filled by the stimulus, and a monitor that checks every FIFO write.
module tb_fifo_wr_arbiter;

  localparam int DSIZE     = 8;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int IW        = 2;
  localparam int W         = IW + DSIZE;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (bus.req_valid),
    .req_data  (bus.req_data),
    .req_last  (bus.req_last),
    .req_ready (bus.req_ready),
    .wfull     (bus.wfull),
    .wreq      (bus.wreq),
    .wdata     (bus.wdata),
    .grant_id  (bus.grant_id),
    .busy      (bus.busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [W-1:0] exp_q[$];
  int           log_cyc[64];
  int           log_n = 0;

  // Beat sources: {last, data} entries, wrapping 4-bit pointers.
  logic [8:0]      src_mem [NREQ][16];
  logic [3:0]      src_wr  [NREQ];
  logic [3:0]      src_rd  [NREQ];
  logic [NREQ-1:0] acc = '0;

  always @(posedge wclk) cyc <= cyc + 1;

  always_comb begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]              = (src_rd[i] != src_wr[i]);
      bus.req_data[i*DSIZE +: DSIZE] = src_mem[i][src_rd[i]][7:0];
      bus.req_last[i]               = src_mem[i][src_rd[i]][8];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #2;
  endtask

  task automatic load(input int id, input logic [7:0] d, input logic last);
    src_mem[id][src_wr[id]] = {last, d};
    src_wr[id] = src_wr[id] + 4'd1;
  endtask

  task automatic expect_beat(input int id, input logic [7:0] d);
    exp_q.push_back({IW'(id), d});
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (log_n < n && k < budget) begin
      @(posedge wclk);
      k++;
    end
    tests_run++;
    if (log_n < n) begin
      tests_failed++;
      $display("FAIL wait_beats: got %0d beats, expected %0d within %0d cycles", log_n, n, budget);
    end
    #2;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    @(negedge wclk);
    while ((exp_q.size() != 0 || bus.busy) && k < budget) begin
      @(negedge wclk);
      k++;
    end
    tests_run++;
    if (exp_q.size() != 0 || bus.busy) begin
      tests_failed++;
      $display("FAIL drain: got %0d beats still expected busy=%0b, expected 0 and 0", exp_q.size(), bus.busy);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard on every FIFO write.
  initial begin
    logic [W-1:0]    e;
    logic [NREQ-1:0] mask;
    forever begin
      @(negedge wclk);
      mask = bus.busy ? (NREQ'(1) << bus.grant_id) : '0;
      check("wreq_while_full", {31'b0, bus.wreq & bus.wfull}, 32'd0);
      check("ready_not_granted", {28'b0, bus.req_ready & ~mask}, 32'd0);
      if (bus.wreq) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_beat: got id %0d data 0x%0h, expected no beat", bus.grant_id, bus.wdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_id_data", {22'b0, bus.grant_id, bus.wdata}, {22'b0, e});
        end
        if (log_n < 64) log_cyc[log_n] = cyc;
        log_n++;
      end
      acc = bus.req_valid & bus.req_ready;
    end
  end

  // Source driver: retire accepted beats just after the edge that took them.
  initial begin
    forever begin
      @(posedge wclk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) src_rd[i] = src_rd[i] + 4'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      src_wr[i] = '0;
      src_rd[i] = '0;
      for (int j = 0; j < 16; j++) src_mem[i][j] = '0;
    end

    // Reset with every requester valid.
    for (int i = 0; i < NREQ; i++) begin
      load(i, 8'h30 + 8'(i), 1'b1);
      expect_beat(i, 8'h30 + 8'(i));
    end
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    check("rst_wreq", {31'b0, bus.wreq}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_ready", {28'b0, bus.req_ready}, 32'd0);
    check("rst_grant", {30'b0, bus.grant_id}, 32'd3);
    tick();
    wrst = 1'b0;
    @(negedge wclk);
    check("post_rst_wreq", {31'b0, bus.wreq}, 32'd0);
    check("post_rst_busy", {31'b0, bus.busy}, 32'd0);
    drain(100);
    check("rst_order_beats", log_n, 32'd4);

    // Single 3-beat packet from requester 1.
    tick();
    log_n = 0;
    load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b0); load(1, 8'h13, 1'b1);
    expect_beat(1, 8'h11); expect_beat(1, 8'h12); expect_beat(1, 8'h13);
    @(negedge wclk);
    check("single_pre_busy", {31'b0, bus.busy}, 32'd0);
    check("single_pre_wreq", {31'b0, bus.wreq}, 32'd0);
    @(negedge wclk);
    check("single_grant", {30'b0, bus.grant_id}, 32'd1);
    check("single_busy", {31'b0, bus.busy}, 32'd1);
    check("single_first_wdata", {24'b0, bus.wdata}, 32'h11);
    drain(100);
    check("single_beats", log_n, 32'd3);
    check("single_consecutive", log_cyc[2] - log_cyc[0], 32'd2);
    check("single_idle_after", cyc - log_cyc[2], 32'd1);

    // Fairness: all valid, last never set, bursts capped at 4.
    tick();
    wrst = 1'b1;
    tick(); tick();
    wrst = 1'b0;
    log_n = 0;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 8; j++) load(i, 8'(i * 16 + j), 1'b0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        for (int j = 0; j < 4; j++) expect_beat(i, 8'(i * 16 + r * 4 + j));
    drain(400);
    check("fair_beats", log_n, 32'd32);
    for (int k = 1; k < 32; k++)
      check("fair_gap", log_cyc[k] - log_cyc[k-1], (k % 4 == 0) ? 32'd2 : 32'd1);

    // Backpressure: wfull for 3 cycles after beat 2 of requester 0.
    tick();
    log_n = 0;
    for (int j = 0; j < 4; j++) begin
      load(0, 8'hA0 + 8'(j), j == 3);
      expect_beat(0, 8'hA0 + 8'(j));
    end
    wait_beats(2, 50);
    bus.wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge wclk);
      check("bp_wreq", {31'b0, bus.wreq}, 32'd0);
      check("bp_ready", {28'b0, bus.req_ready}, 32'd0);
      check("bp_busy", {31'b0, bus.busy}, 32'd1);
      check("bp_grant", {30'b0, bus.grant_id}, 32'd0);
      tick();
    end
    bus.wfull = 1'b0;
    drain(100);
    check("bp_beats", log_n, 32'd4);

    // Reset in the middle of requester 2's packet.
    tick();
    log_n = 0;
    for (int j = 0; j < 4; j++) load(2, 8'hC0 + 8'(j), j == 3);
    expect_beat(2, 8'hC0);
    wait_beats(1, 50);
    wrst = 1'b1;
    @(negedge wclk);
    check("mid_rst_wreq", {31'b0, bus.wreq}, 32'd0);
    check("mid_rst_ready", {28'b0, bus.req_ready}, 32'd0);
    tick();
    @(negedge wclk);
    check("mid_rst_idle", {31'b0, bus.busy}, 32'd0);
    check("mid_rst_wreq2", {31'b0, bus.wreq}, 32'd0);
    check("mid_rst_grant", {30'b0, bus.grant_id}, 32'd3);
    for (int i = 0; i < NREQ; i++) src_rd[i] = src_wr[i];
    load(0, 8'h01, 1'b0); load(0, 8'h02, 1'b1);
    load(2, 8'hC8, 1'b0); load(2, 8'hC9, 1'b1);
    expect_beat(0, 8'h01); expect_beat(0, 8'h02);
    expect_beat(2, 8'hC8); expect_beat(2, 8'hC9);
    tick();
    wrst = 1'b0;
    drain(100);
    check("mid_rst_beats", log_n, 32'd5);

    // Last flag on the MAX_BURST-th beat: one exit, one bubble.
    tick();
    log_n = 0;
    for (int j = 0; j < 4; j++) begin
      load(3, 8'hD0 + 8'(j), j == 3);
      expect_beat(3, 8'hD0 + 8'(j));
    end
    load(0, 8'hE0, 1'b1);
    load(1, 8'hF0, 1'b1);
    expect_beat(0, 8'hE0);
    expect_beat(1, 8'hF0);
    drain(100);
    check("coinc_beats", log_n, 32'd6);
    check("coinc_burst_len", log_cyc[3] - log_cyc[0], 32'd3);
    check("coinc_bubble", log_cyc[4] - log_cyc[3], 32'd2);
    check("coinc_next_bubble", log_cyc[5] - log_cyc[4], 32'd2);
    check("coinc_src3_empty", {28'b0, src_wr[3] - src_rd[3]}, 32'd0);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
